// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//   Multi-cycle instruction sequencer sitting between IR fetch and the
//   datapath. Accepts one instruction per ir_valid/ir_ready handshake, drives
//   the 14-bit control word for one or more cycles, stalls memory operations
//   until mem_ack (with an optional timeout) and takes latched hardware
//   interrupts only at instruction boundaries.
//
//   Optional feature: define INST_SEQ_RETIRE_CNT_EN to add the retire_cnt
//   output (count of normally completed instructions, wraps at 2^32).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en             allows new instructions / interrupt entry to start
//   int_en         global interrupt enable (gates latching of hardware_int)
//   hardware_int   level interrupt request
//   ir_valid       instruction available       (in)
//   ir_ready       sequencer can accept        (out)
//   opcode, sub_flags, func_1  instruction fields, sampled on accept
//   mem_ack        single-cycle memory completion pulse
//   control_lines  datapath control word
//   int_ack        1-cycle pulse after interrupt entry completes
//   illegal_op     1-cycle pulse while an illegal opcode sits in EXEC
//   mem_fault      1-cycle pulse when a memory wait times out
//   busy           sequencer is not idle
//   retire_cnt     (INST_SEQ_RETIRE_CNT_EN only) retired instruction count
//
// Handshake: an instruction transfers on a rising clk edge where
// ir_valid && ir_ready are both high; ir_valid may be held across cycles
// while ir_ready is low and the fields must stay stable until the transfer.
// -----------------------------------------------------------------------------
module inst_sequencer #(
   parameter int OPCODE_W    = 5,
   parameter int NUM_FLAGS   = 4,
   parameter int FUNC_W      = 4,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 int_en,
   input  logic                 hardware_int,
   input  logic                 ir_valid,
   output logic                 ir_ready,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [NUM_FLAGS-1:0] sub_flags,
   input  logic [FUNC_W-1:0]    func_1,
   input  logic                 mem_ack,
   output logic [13:0]          control_lines,
   output logic                 int_ack,
   output logic                 illegal_op,
   output logic                 mem_fault,
   output logic                 busy
`ifdef INST_SEQ_RETIRE_CNT_EN
   ,
   output logic [31:0]          retire_cnt
`else
`endif
);

   localparam int COND_W = 2 * NUM_FLAGS;
   localparam int CSEL_W = $clog2(COND_W);
   localparam int CNT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [13:0] INT_WORD = 14'h3C74;

   if (CSEL_W > FUNC_W) begin : g_bad_func_w
      $error("inst_sequencer: FUNC_W is too narrow for the condition select");
   end

   // Only the low CSEL_W bits of func_1 select a condition.
   if (FUNC_W > CSEL_W) begin : g_func_hi
      logic func_hi_unused;
      assign func_hi_unused = ^func_1[FUNC_W-1:CSEL_W];
   end

   typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, INT_ENTRY} state_t;

   state_t               state, state_n;
   logic [OPCODE_W-1:0]  opcode_q;
   logic [NUM_FLAGS-1:0] flags_q;
   logic [CSEL_W-1:0]    sel_q;
   logic                 int_pending, int_ack_q, int_done;
   logic [CNT_W-1:0]     wait_cnt, wait_cnt_n;
   logic                 timed_out, illegal, fout;
   logic [13:0]          word;
   logic [(2**CSEL_W)-1:0] cond_pad;

   function automatic logic [13:0] decode(input logic [OPCODE_W-1:0] op, input logic f);
      logic [13:0] w;
      w = 14'h0000;
      case (op)
         OPCODE_W'(0): w = 14'h0001;
         OPCODE_W'(1): w = 14'h0003;
         OPCODE_W'(2): w = 14'h0101;
         OPCODE_W'(3): w = 14'h0008;
         OPCODE_W'(4): w = 14'h2601;
         OPCODE_W'(5): w = 14'h0044;
         OPCODE_W'(6): w = 14'h0004;
         OPCODE_W'(7): w = 14'h0020 | {11'd0, f, 2'b00};
         OPCODE_W'(8): w = 14'h2874;
         default:      w = 14'h0000;
      endcase
      return w;
   endfunction

   // Condition vector padded to a power of two so out-of-range selects read 0.
   always_comb begin
      cond_pad = '0;
      cond_pad[COND_W-1:0] = {~flags_q, flags_q};
      fout = cond_pad[sel_q];
   end

   assign word      = decode(opcode_q, fout);
   assign illegal   = (opcode_q >= OPCODE_W'(9));
   assign timed_out = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
   // ir_ready is the one output allowed to see an input (en); rst_n keeps it low in reset.
   assign ir_ready  = rst_n && (state == IDLE) && en && !int_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         opcode_q    <= '0;
         flags_q     <= '0;
         sel_q       <= '0;
         int_pending <= 1'b0;
         int_ack_q   <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         state     <= state_n;
         wait_cnt  <= wait_cnt_n;
         int_ack_q <= int_done;
         // A new request in the completing cycle keeps the interrupt pending.
         int_pending <= (int_pending && !int_done) || (hardware_int && int_en);
         if (ir_valid && ir_ready) begin
            opcode_q <= opcode;
            flags_q  <= sub_flags;
            sel_q    <= func_1[CSEL_W-1:0];
         end
      end
   end

   always_comb begin
      state_n    = state;
      wait_cnt_n = '0;
      int_done   = 1'b0;
      case (state)
         IDLE: begin
            if (en && int_pending)
               state_n = INT_ENTRY;
            else if (ir_valid && ir_ready)
               state_n = EXEC;
         end
         EXEC: begin
            // A mem_ack already present in EXEC completes the access here.
            if (!illegal && word[13] && !mem_ack)
               state_n = MEM_WAIT;
            else
               state_n = IDLE;
         end
         MEM_WAIT: begin
            if (timed_out || mem_ack)
               state_n = IDLE;
            else if (MEM_TIMEOUT > 0)
               wait_cnt_n = wait_cnt + CNT_W'(1);
         end
         INT_ENTRY: begin
            // Timeout wins over a late ack; int_pending stays set for a retry.
            if (timed_out) begin
               state_n = IDLE;
            end else if (mem_ack) begin
               state_n  = IDLE;
               int_done = 1'b1;
            end else if (MEM_TIMEOUT > 0) begin
               wait_cnt_n = wait_cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      control_lines = 14'h0000;
      case (state)
         EXEC:      control_lines = illegal ? 14'h0000 : word;
         MEM_WAIT:  control_lines = word;
         INT_ENTRY: control_lines = INT_WORD;
         default:   control_lines = 14'h0000;
      endcase
   end

   assign illegal_op = (state == EXEC) && illegal;
   assign mem_fault  = timed_out && ((state == MEM_WAIT) || (state == INT_ENTRY));
   assign int_ack    = int_ack_q;
   assign busy       = (state != IDLE);

`ifdef INST_SEQ_RETIRE_CNT_EN
   logic retire;
   assign retire = ((state == EXEC) && !illegal && (!word[13] || mem_ack)) ||
                   ((state == MEM_WAIT) && mem_ack && !timed_out);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retire_cnt <= 32'd0;
      else if (retire)
         retire_cnt <= retire_cnt + 32'd1;
   end
`else
   // No retire counter in this build.
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
//   Bench for inst_sequencer built with MEM_TIMEOUT=4. Each transaction task
//   turns the instruction/interrupt it issues into the list of per-cycle output
//   vectors the sequencer must show and pushes them on exp_q; one process
//   compares every cycle against the queue head, or against the idle vector
//   when nothing is outstanding.
//   Vector layout: {control_lines[13:0], busy, illegal_op, mem_fault, int_ack, ir_ready}
// -----------------------------------------------------------------------------
module tb_inst_sequencer;

   localparam int TO = 4;

   logic        clk, rst_n, en, int_en, hardware_int, ir_valid, ir_ready, mem_ack;
   logic [4:0]  opcode;
   logic [3:0]  sub_flags, func_1;
   logic [13:0] control_lines;
   logic        int_ack, illegal_op, mem_fault, busy;
`ifdef INST_SEQ_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   logic [18:0] exp_q[$];
   logic        chk_en;
   int          n_cmp, n_err;

   inst_sequencer #(
      .OPCODE_W(5), .NUM_FLAGS(4), .FUNC_W(4), .MEM_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .int_en(int_en),
      .hardware_int(hardware_int), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .opcode(opcode), .sub_flags(sub_flags), .func_1(func_1),
      .mem_ack(mem_ack), .control_lines(control_lines), .int_ack(int_ack),
      .illegal_op(illegal_op), .mem_fault(mem_fault), .busy(busy)
`ifdef INST_SEQ_RETIRE_CNT_EN
      , .retire_cnt(retire_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference helpers ----------------
   function automatic logic [18:0] ent(input logic [13:0] c, input logic b, input logic il,
                                       input logic mf, input logic ia, input logic rdy);
      return {c, b, il, mf, ia, rdy};
   endfunction

   function automatic logic [18:0] cur();
      return {control_lines, busy, illegal_op, mem_fault, int_ack, ir_ready};
   endfunction

   // Control word from the instruction table; condition = {~flags, flags}[func low bits].
   function automatic logic [13:0] model_word(input int op, input logic [3:0] fl, input logic [3:0] fn);
      logic [13:0] base [0:8];
      int s;
      logic f;
      base = '{14'h0001, 14'h0003, 14'h0101, 14'h0008, 14'h2601,
               14'h0044, 14'h0004, 14'h0020, 14'h2874};
      if (op > 8) return 14'h0000;
      s = int'(fn) % 8;
      f = (s < 4) ? fl[s] : ~fl[s-4];
      return (op == 7 && f) ? (base[op] | 14'h0004) : base[op];
   endfunction

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      logic [18:0] e_v, a_v;
      if (chk_en) begin
         a_v = cur();
         if (exp_q.size() > 0) e_v = exp_q.pop_front();
         else                  e_v = ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, en);
         n_cmp++;
         if (a_v !== e_v) begin
            n_err++;
            $display("FAIL cycle@%0t: got ctl=%h b/il/mf/ia/rdy=%b, required ctl=%h b/il/mf/ia/rdy=%b",
                     $time, a_v[18:5], a_v[4:0], e_v[18:5], e_v[4:0]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [18:0] act, input logic [18:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 50) begin
         @(posedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d expected cycles left over, required 0", exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   // d = cycles after EXEC at which mem_ack is pulsed (0 = during EXEC); d > 10 means never.
   task automatic do_instr(input int op, input logic [3:0] fl, input logic [3:0] fn,
                           input int d, input logic [13:0] w, input logic drop_en);
      @(posedge clk); #1;
      en = 1'b1; ir_valid = 1'b1; opcode = 5'(op); sub_flags = fl; func_1 = fn;
      @(posedge clk);
      if (op >= 9)
         exp_q.push_back(ent(14'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (!w[13])
         exp_q.push_back(ent(w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (d <= TO)
         repeat (d + 1) exp_q.push_back(ent(w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      else begin
         repeat (TO + 1) exp_q.push_back(ent(w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(ent(w, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      #1;
      ir_valid = 1'b0;
      opcode = 5'($urandom); sub_flags = 4'($urandom); func_1 = 4'($urandom);
      if (drop_en) en = 1'b0;
      if (op < 9 && w[13] && d <= 10) begin
         repeat (d) begin @(posedge clk); #1; end
         mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      drain();
      en = 1'b1;
   endtask

   // d = entry cycle carrying mem_ack; d >= TO times out first, then the retry is acked at once.
   task automatic do_int(input int d, input logic drop_int_en);
      @(posedge clk); #1;
      en = 1'b1; hardware_int = 1'b1; int_en = 1'b1;
      @(posedge clk);
      exp_q.push_back(ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (d < TO) begin
         repeat (d + 1) exp_q.push_back(ent(14'h3C74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
         repeat (TO) exp_q.push_back(ent(14'h3C74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(ent(14'h3C74, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         exp_q.push_back(ent(14'h3C74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      exp_q.push_back(ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      #1;
      hardware_int = 1'b0;
      if (drop_int_en) int_en = 1'b0;
      @(posedge clk); #1;
      if (d < TO) begin
         repeat (d) begin @(posedge clk); #1; end
      end else begin
         repeat (TO + 2) begin @(posedge clk); #1; end
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      int_en = 1'b1;
      drain();
   endtask

   // Request raised while interrupts are disabled must not be latched.
   task automatic masked_int();
      @(posedge clk); #1;
      int_en = 1'b0; hardware_int = 1'b1;
      @(posedge clk); #1;
      hardware_int = 1'b0; int_en = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // en low holds off acceptance even with ir_valid asserted.
   task automatic en_low(input int n);
      @(posedge clk); #1;
      en = 1'b0; ir_valid = 1'b1; opcode = 5'($urandom_range(0, 8));
      repeat (n) begin @(posedge clk); #1; end
      ir_valid = 1'b0; en = 1'b1;
   endtask

   // Interrupt and instruction arrive together; the interrupt is served first.
   task automatic int_vs_instr();
      @(posedge clk); #1;
      en = 1'b0; ir_valid = 1'b1; opcode = 5'd1; sub_flags = 4'd0; func_1 = 4'd0;
      hardware_int = 1'b1; int_en = 1'b1;
      @(posedge clk);
      exp_q.push_back(ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ent(14'h3C74, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(ent(14'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(ent(14'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      #1;
      hardware_int = 1'b0; en = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      ir_valid = 1'b0;
      drain();
   endtask

   task automatic reset_mid();
      chk_en = 1'b0;
      @(posedge clk); #1;
      ir_valid = 1'b1; opcode = 5'd4; sub_flags = 4'd0; func_1 = 4'd0;
      @(posedge clk); #1;
      ir_valid = 1'b0;
      @(posedge clk); #1;
      check_lit("mem_wait_before_reset", cur(), ent(14'h2601, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      check_lit("reset_mid_outputs", cur(), 19'h0);
      @(posedge clk); #1;
      check_lit("reset_held_outputs", cur(), 19'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k, op, d;
      logic [3:0] fl, fn;
      n_cmp = 0; n_err = 0; chk_en = 1'b0;
      rst_n = 1'b0; en = 1'b1; int_en = 1'b1; hardware_int = 1'b0;
      ir_valid = 1'b0; opcode = '0; sub_flags = '0; func_1 = '0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_outputs", cur(), 19'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      do_instr(1, 4'd0, 4'd0, 0, 14'h0003, 1'b0);        // ALUI, one cycle
      do_instr(4, 4'd0, 4'd0, 3, 14'h2601, 1'b0);        // LOAD, ack 3 after EXEC
      do_instr(4, 4'd0, 4'd0, 0, 14'h2601, 1'b0);        // LOAD, ack in EXEC
      do_instr(7, 4'b0010, 4'd1, 0, 14'h0024, 1'b0);     // CJMP taken
      do_instr(7, 4'b0010, 4'd5, 0, 14'h0020, 1'b0);     // CJMP not taken
      int_vs_instr();
      do_instr(8, 4'd0, 4'd0, 99, 14'h2874, 1'b0);       // SYSCALL timeout
      do_instr(3, 4'd0, 4'd0, 0, 14'h0008, 1'b1);        // en dropped in flight
      reset_mid();
      do_instr(9, 4'd0, 4'd0, 0, 14'h0000, 1'b0);        // illegal
      do_int(1, 1'b0);
      do_int(TO, 1'b1);                                  // entry times out, retried
      masked_int();

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 9);
         if (k < 7) begin
            op = $urandom_range(0, 10);
            fl = 4'($urandom);
            fn = 4'($urandom);
            d  = $urandom_range(0, 6);
            do_instr(op, fl, fn, d, model_word(op, fl, fn), ($urandom_range(0, 4) == 0));
         end else if (k == 7) begin
            do_int($urandom_range(0, TO), 1'($urandom_range(0, 1)));
         end else if (k == 8) begin
            masked_int();
         end else begin
            en_low($urandom_range(1, 4));
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Multi-cycle successor to the SRM-Starter combinational instruction decoder. Sits between IR fetch and the datapath.
- Accepts one instruction per handshake and drives the 14-bit control word for one or more cycles. Stalls on memory requests until acknowledged.
- Latches hardware interrupts and takes them only at instruction boundaries.
- Condition-flag count, opcode width, func width and memory timeout are parametrised.

Parameters:
- OPCODE_W, 5: opcode width; opcodes >= 9 are illegal.
- NUM_FLAGS, 4: number of sub_flags; cond vector = {~sub_flags, sub_flags}, width 2*NUM_FLAGS.
- FUNC_W, 4: func_1 width; condition select uses the low CSEL_W = $clog2(2*NUM_FLAGS) bits. Elaboration error if CSEL_W > FUNC_W.
- MEM_TIMEOUT, 0: maximum wait cycles for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enables acceptance of new instructions and interrupts.
- int_en  in  1  global interrupt enable.
- hardware_int  in  1  level interrupt request.
- ir_valid  in  1  instruction available.
- ir_ready  out  1  sequencer can accept; high only in IDLE with en=1 and no pending interrupt.
- opcode  in  OPCODE_W  instruction opcode, sampled on accept.
- sub_flags  in  NUM_FLAGS  ALU flags, sampled on accept.
- func_1  in  FUNC_W  function/condition field, sampled on accept.
- mem_ack  in  1  memory completion; single-cycle pulse.
- control_lines  out  14  datapath control word; bit map below.
- int_ack  out  1  1-cycle pulse when interrupt entry completes.
- illegal_op  out  1  1-cycle pulse on an illegal opcode.
- mem_fault  out  1  1-cycle pulse on memory timeout.
- busy  out  1  state != IDLE.

Behaviour:
- control_lines bit map: 0 C_WE, 1 ALU_Bsel, 2 PC_JMP, 3 MEM_WE, 4 KS, 5-7 PC_IN, 8-9 REG_IN, 10-11 MEM_ADDR, 12 IR_tsf, 13 Mem_REQ.
- Decode table:
  - 0 ALU 0x0001
  - 1 ALUI 0x0003
  - 2 LUI 0x0101
  - 3 STORE 0x0008
  - 4 LOAD 0x2601
  - 5 IJR 0x0044
  - 6 JMP 0x0004
  - 7 CJMP 0x0020 | (fout<<2)
  - 8 SYSCALL 0x2874
  - interrupt entry 0x3C74
- fout = cond[func_1[CSEL_W-1:0]]. An index >= 2*NUM_FLAGS gives fout=0.
- States:
  - IDLE: control_lines=0.
    - Interrupt priority: if en && int_pending, go to INT_ENTRY; an interrupt wins over a simultaneous ir_valid.
    - Otherwise, if ir_valid && ir_ready: latch opcode, func_1 and sub_flags, then go to EXEC.
  - EXEC: control_lines = decode(latched) for exactly one cycle.
    - If Mem_REQ (bit 13) is set, go to MEM_WAIT.
    - Illegal opcode: control_lines=0, pulse illegal_op, go to IDLE.
    - Otherwise go to IDLE.
  - MEM_WAIT: hold the same control_lines until mem_ack, then go to IDLE.
  - INT_ENTRY: control_lines=0x3C74. Wait for mem_ack (the same MEM_WAIT rules apply), then pulse int_ack, clear int_pending, go to IDLE.
- mem_ack timing: a mem_ack during EXEC is honoured and completes the instruction in that cycle, with no MEM_WAIT cycle. A mem_ack in IDLE is ignored.
- int_pending:
  - Set on any cycle with hardware_int && int_en.
  - Cleared only by completion of INT_ENTRY (and by reset).
  - Dropping int_en after the interrupt is latched does not cancel it.
- Timeout: when MEM_TIMEOUT > 0, a counter increments each MEM_WAIT / INT_ENTRY cycle without mem_ack. On reaching MEM_TIMEOUT: pulse mem_fault, drive control_lines=0 next cycle, go to IDLE. A timed-out interrupt entry leaves int_pending set, so it is retried.
- Latency: accept at edge N; control word valid in cycle N+1; earliest next accept at edge N+2 for non-memory ops.
- en=0 blocks only new acceptance. An instruction already in flight completes.
- Reset (async, any state): state=IDLE, int_pending=0, counter=0. All outputs 0 except ir_ready, which follows its definition (0 while in reset).
- All outputs are Moore: driven from state and latched registers only, no combinational path from inputs. Exception: ir_ready depends on en.

Optional Feature:
- Macro INST_SEQ_RETIRE_CNT_EN.
- When defined: adds output retire_cnt [31:0], reset 0. It increments once per instruction leaving EXEC or MEM_WAIT normally, wraps at 2^32, and does not count illegal ops, faults or interrupt entries.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALUI handshake: accept opcode=1 → control_lines=0x0003 for exactly 1 cycle, busy=1 for 1 cycle, back in IDLE.
- LOAD stall: opcode=4, mem_ack asserted 3 cycles after EXEC → control_lines=0x2601 held 4 cycles, then 0.
- Conditional jump: opcode=7, sub_flags=4'b0010.
  - func_1=1 → control_lines=0x0024.
  - func_1=5 → control_lines=0x0020.
- Interrupt vs instruction: hardware_int=1 and int_en=1 in the same cycle as ir_valid in IDLE → INT_ENTRY with 0x3C74; after mem_ack, int_ack pulses; then the instruction is accepted.
- Timeout (MEM_TIMEOUT=4): opcode=8 with no mem_ack → mem_fault pulses after 4 wait cycles; next cycle control_lines=0 and state IDLE.
- Reset mid-operation: assert rst_n=0 during MEM_WAIT → all outputs 0 immediately. Then opcode=9 → illegal_op pulses once and control_lines stays 0.
